// File: rtl/barrel_shift_engine.sv
// Multi-cycle barrel shifter: LSL/LSR/ASR/ROL, up to STEP bits per clock.
// Define BSE_ABORT_EN to add the abort port that cancels a running shift.
module barrel_shift_engine #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             preset_L,
  input  logic             start,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    amount,
  input  logic [1:0]       mode,
`ifdef BSE_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  state_t           state, state_n;
  logic [AW-1:0]    rem, rem_n;
  logic [1:0]       mode_q, mode_n;
  logic [WIDTH-1:0] q_n, sh_q;
  logic             c_n, sh_c;
  logic [AW-1:0]    k;
  logic             accept;
  logic             kill;

`ifdef BSE_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign accept = start && (state != S_SHIFT);
  assign k      = (rem < STEP_A) ? rem : STEP_A;

  // Unrolled single-bit steps; only the first k are applied.
  always_comb begin
    sh_q = Q;
    sh_c = carry;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(k)) begin
        unique case (mode_q)
          M_LSL: begin
            sh_c = sh_q[WIDTH-1];
            sh_q = {sh_q[WIDTH-2:0], 1'b0};
          end
          M_LSR: begin
            sh_c = sh_q[0];
            sh_q = {1'b0, sh_q[WIDTH-1:1]};
          end
          M_ASR: begin
            sh_c = sh_q[0];
            sh_q = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
          end
          M_ROL: begin
            sh_c = sh_q[WIDTH-1];
            sh_q = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
          end
        endcase
      end
    end
  end

  always_comb begin
    state_n = state;
    q_n     = Q;
    c_n     = carry;
    rem_n   = rem;
    mode_n  = mode_q;
    if (kill) begin
      state_n = S_IDLE;
    end else if (accept) begin
      q_n     = D;
      c_n     = 1'b0;
      rem_n   = amount;
      mode_n  = mode;
      state_n = (amount != '0) ? S_SHIFT : S_DONE;
    end else begin
      unique case (state)
        S_SHIFT: begin
          q_n     = sh_q;
          c_n     = sh_c;
          rem_n   = rem - k;
          state_n = (rem <= STEP_A) ? S_DONE : S_SHIFT;
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge preset_L) begin
    if (!preset_L) begin
      state  <= S_IDLE;
      Q      <= '0;
      carry  <= 1'b0;
      rem    <= '0;
      mode_q <= M_LSL;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      Q      <= q_n;
      carry  <= c_n;
      rem    <= rem_n;
      mode_q <= mode_n;
      busy   <= (state_n == S_SHIFT);
      done   <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_barrel_shift_engine.sv
// Directed bench for barrel_shift_engine, WIDTH=8 STEP=2.
// With BSE_ABORT_EN defined the abort scenario is also exercised.
module tb_barrel_shift_engine;

  logic       clock;
  logic       preset_L;
  logic       start;
  logic [7:0] D;
  logic [2:0] amount;
  logic [1:0] mode;
`ifdef BSE_ABORT_EN
  logic       abort;
`endif
  logic [7:0] Q;
  logic       carry;
  logic       busy;
  logic       done;

  int n_chk;
  int n_pass;

  barrel_shift_engine #(
    .WIDTH(8),
    .STEP (2)
  ) dut (
    .clock   (clock),
    .preset_L(preset_L),
    .start   (start),
    .D       (D),
    .amount  (amount),
    .mode    (mode),
`ifdef BSE_ABORT_EN
    .abort   (abort),
`endif
    .Q       (Q),
    .carry   (carry),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Start is accepted at the posedge between the two negedges.
  task automatic launch(input logic [7:0] d,
                        input logic [2:0] amt,
                        input logic [1:0] md);
    @(negedge clock);
    D      = d;
    amount = amt;
    mode   = md;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int nb);
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int g = 0; g < 20; g++) begin
      chk({tag, "_excl"}, 32'(busy && done), 0);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clock);
    end
    chk({tag, "_seen"}, 32'(seen), 1);
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] d,
                        input logic [2:0] amt,
                        input logic [1:0] md,
                        input int exp_nb,
                        input logic [7:0] exp_q,
                        input logic exp_c);
    int nb;
    launch(d, amt, md);
    wait_done(tag, nb);
    chk({tag, "_busy"}, 32'(nb), 32'(exp_nb));
    chk({tag, "_q"}, 32'(Q), 32'(exp_q));
    chk({tag, "_c"}, 32'(carry), 32'(exp_c));
  endtask

  initial begin
    int nb;
    n_chk    = 0;
    n_pass   = 0;
    start    = 1'b0;
    D        = '0;
    amount   = '0;
    mode     = '0;
`ifdef BSE_ABORT_EN
    abort    = 1'b0;
`endif
    preset_L = 1'b1;
    #1 preset_L = 1'b0;
    #1;
    chk("rst_q", 32'(Q), 0);
    chk("rst_c", 32'(carry), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clock);
    preset_L = 1'b1;

    run_op("lsl", 8'h96, 3'd3, 2'b00, 2, 8'hB0, 1'b0);
    run_op("asr", 8'h96, 3'd5, 2'b10, 3, 8'hFC, 1'b1);
    run_op("rol", 8'h81, 3'd7, 2'b11, 4, 8'hC0, 1'b0);
    run_op("lsr", 8'h96, 3'd3, 2'b01, 2, 8'h12, 1'b1);
    run_op("zero", 8'h5A, 3'd0, 2'b00, 0, 8'h5A, 1'b0);

    @(negedge clock);
    chk("pulse_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_q", 32'(Q), 32'h5A);

    // Start during SHIFT must be ignored.
    launch(8'h96, 3'd5, 2'b10);
    D      = 8'hFF;
    amount = 3'd1;
    mode   = 2'b00;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    wait_done("ign", nb);
    chk("ign_busy", 32'(nb), 2);
    chk("ign_q", 32'(Q), 32'hFC);
    chk("ign_c", 32'(carry), 1);

    // Start held through DONE is taken with no IDLE gap.
    launch(8'h96, 3'd3, 2'b00);
    wait_done("b2b_a", nb);
    D      = 8'h01;
    amount = 3'd1;
    mode   = 2'b00;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_ndone", 32'(done), 0);
    wait_done("b2b_b", nb);
    chk("b2b_q", 32'(Q), 32'h02);
    chk("b2b_c", 32'(carry), 0);

    // Asynchronous reset mid-shift.
    launch(8'h96, 3'd7, 2'b00);
    @(negedge clock);
    chk("prst_pre", 32'(busy), 1);
    #2 preset_L = 1'b0;
    #1;
    chk("prst_q", 32'(Q), 0);
    chk("prst_busy", 32'(busy), 0);
    chk("prst_done", 32'(done), 0);
    chk("prst_c", 32'(carry), 0);
    #1 preset_L = 1'b1;

`ifdef BSE_ABORT_EN
    launch(8'h96, 3'd5, 2'b10);
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abt_busy", 32'(busy), 0);
    chk("abt_done", 32'(done), 0);
    chk("abt_q", 32'(Q), 32'hE5);
    chk("abt_c", 32'(carry), 1);
    @(negedge clock);
    chk("abt_nodone", 32'(done), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
